// File: rtl/clock_pkg.sv
// Shared types and limits for the 12-hour time-of-day counter.
package clock_pkg;

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      SET_H = 2'd1,
      SET_M = 2'd2,
      SET_S = 2'd3
   } set_state_t;

   localparam logic [5:0] MAX_SEC    = 6'd59;
   localparam logic [5:0] MAX_MIN    = 6'd59;
   localparam logic [3:0] MAX_HOUR   = 4'd12;
   localparam logic [3:0] RESET_HOUR = 4'd12;

   // 12-hour wrap: 12 is followed by 1, never by 0 or 13.
   function automatic logic [3:0] next_hour(input logic [3:0] h);
      return (h == MAX_HOUR) ? 4'd1 : h + 4'd1;
   endfunction

endpackage

// File: rtl/tick_gen.sv
// Prescaler dividing clk down to a one-cycle strobe every CLK_HZ cycles.
module tick_gen #(
   parameter int unsigned CLK_HZ = 50_000_000
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   output logic tick
);

   localparam int unsigned CW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
   localparam logic [CW-1:0] TERM = CW'(CLK_HZ - 1);

   logic [CW-1:0] count;
   logic [CW-1:0] count_next;

   always_comb begin
      count_next = (count == TERM) ? '0 : count + 1'b1;
   end

   // tick is registered from the next count so it is high exactly while count==TERM.
   always_ff @(posedge clk) begin
      if (rst || !en) begin
         count <= '0;
         tick  <= 1'b0;
      end else begin
         count <= count_next;
         tick  <= (count_next == TERM);
      end
   end

endmodule

// File: rtl/time_counter.sv
// 12-hour clock with AM/PM, 1 Hz run mode and a button-driven field set mode.
module time_counter
   import clock_pkg::*;
#(
   parameter int unsigned CLK_HZ = 50_000_000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       mode_btn,
   input  logic       inc_btn,
   output logic [3:0] hours,
   output logic [5:0] mins,
   output logic [5:0] secs,
   output logic       pm,
   output logic [1:0] set_field,
   output logic       sec_tick
);

   set_state_t state;
   logic       run_en;

   // Dropping enable on the mode press clears the prescaler on the same edge
   // that leaves RUN, and keeps it at 0 on the edge that returns to RUN.
   assign run_en = (state == RUN) && !mode_btn;

   tick_gen #(.CLK_HZ(CLK_HZ)) u_tick_gen (
      .clk  (clk),
      .rst  (rst),
      .en   (run_en),
      .tick (sec_tick)
   );

   assign set_field = state;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= RUN;
         hours <= RESET_HOUR;
         mins  <= '0;
         secs  <= '0;
         pm    <= 1'b0;
      end else begin
         unique case (state)
            RUN: begin
               if (mode_btn) state <= SET_H;
               if (sec_tick) begin
                  if (secs == MAX_SEC) begin
                     secs <= '0;
                     if (mins == MAX_MIN) begin
                        mins  <= '0;
                        hours <= next_hour(hours);
                        if (hours == MAX_HOUR - 4'd1) pm <= ~pm;
                     end else begin
                        mins <= mins + 6'd1;
                     end
                  end else begin
                     secs <= secs + 6'd1;
                  end
               end
            end
            SET_H: begin
               if (mode_btn) begin
                  state <= SET_M;
               end else if (inc_btn) begin
                  hours <= next_hour(hours);
                  if (hours == MAX_HOUR - 4'd1) pm <= ~pm;
               end
            end
            SET_M: begin
               if (mode_btn)     state <= SET_S;
               else if (inc_btn) mins  <= (mins == MAX_MIN) ? '0 : mins + 6'd1;
            end
            SET_S: begin
               if (mode_btn)     state <= RUN;
               else if (inc_btn) secs  <= (secs == MAX_SEC) ? '0 : secs + 6'd1;
            end
            default: state <= RUN;
         endcase
      end
   end

endmodule

// File: tb/tb_time_counter.sv
// Directed, table-driven bench for time_counter with a 4-cycle second.
module tb_time_counter;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       mode_btn = 1'b0;
   logic       inc_btn = 1'b0;
   logic [3:0] hours;
   logic [5:0] mins;
   logic [5:0] secs;
   logic       pm;
   logic [1:0] set_field;
   logic       sec_tick;

   int errors = 0;
   int checks = 0;

   time_counter #(.CLK_HZ(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .mode_btn  (mode_btn),
      .inc_btn   (inc_btn),
      .hours     (hours),
      .mins      (mins),
      .secs      (secs),
      .pm        (pm),
      .set_field (set_field),
      .sec_tick  (sec_tick)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic m;
      logic i;
      int   h;
      int   mi;
      int   s;
      int   p;
      int   f;
   } vec_t;

   vec_t tbl[19];

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic check_time(input string name, input int h, input int mi,
                             input int s, input int p, input int f);
      check({name, ".hours"}, int'(hours), h);
      check({name, ".mins"}, int'(mins), mi);
      check({name, ".secs"}, int'(secs), s);
      check({name, ".pm"}, int'(pm), p);
      check({name, ".set_field"}, int'(set_field), f);
   endtask

   // Drive one cycle of buttons; returns #1 after the capturing edge.
   task automatic step(input logic m, input logic i);
      @(negedge clk);
      mode_btn = m;
      inc_btn  = i;
      @(posedge clk);
      #1;
      mode_btn = 1'b0;
      inc_btn  = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic incs(input int n);
      for (int k = 0; k < n; k++) step(1'b0, 1'b1);
   endtask

   // From RUN: walk all set states, applying nh/nm/ns increments, back to RUN.
   task automatic set_fields(input int nh, input int nm, input int ns);
      step(1'b1, 1'b0);
      incs(nh);
      step(1'b1, 1'b0);
      incs(nm);
      step(1'b1, 1'b0);
      incs(ns);
      step(1'b1, 1'b0);
   endtask

   // Waits for sec_tick (bounded), reports the cycle it appeared on, then
   // steps past the edge that applies it.
   task automatic wait_tick(input string name, input int exp_cycle);
      int n = 1;
      while (!sec_tick && n < 20) begin
         @(posedge clk);
         #1;
         n++;
      end
      check({name, ".tick_cycle"}, n, exp_cycle);
      @(posedge clk);
      #1;
   endtask

   function automatic vec_t mk(input logic m, input logic i, input int h,
                               input int mi, input int s, input int p,
                               input int f);
      vec_t v;
      v.m = m; v.i = i; v.h = h; v.mi = mi; v.s = s; v.p = p; v.f = f;
      return v;
   endfunction

   initial begin
      tbl[0] = mk(1'b1, 1'b0, 12, 0, 0, 0, 1);
      for (int k = 1; k <= 11; k++) tbl[k] = mk(1'b0, 1'b1, k, 0, 0, 0, 1);
      tbl[12] = mk(1'b0, 1'b1, 12, 0, 0, 1, 1);
      tbl[13] = mk(1'b0, 1'b1, 1, 0, 0, 1, 1);
      tbl[14] = mk(1'b1, 1'b1, 1, 0, 0, 1, 2);
      tbl[15] = mk(1'b0, 1'b1, 1, 1, 0, 1, 2);
      tbl[16] = mk(1'b1, 1'b0, 1, 1, 0, 1, 3);
      tbl[17] = mk(1'b0, 1'b1, 1, 1, 1, 1, 3);
      tbl[18] = mk(1'b1, 1'b0, 1, 1, 1, 1, 0);

      // Reset state and tick spacing
      do_reset();
      check_time("reset", 12, 0, 0, 0, 0);
      check("reset.sec_tick", int'(sec_tick), 0);
      for (int c = 1; c <= 12; c++) begin
         check($sformatf("spacing.c%0d", c), int'(sec_tick), (c % 4 == 0) ? 1 : 0);
         @(posedge clk);
         #1;
      end
      check("spacing.secs", int'(secs), 3);

      // Set-mode table: hours walk, collision, minute/second increments
      do_reset();
      for (int k = 0; k < 19; k++) begin
         step(tbl[k].m, tbl[k].i);
         check_time($sformatf("tbl%0d", k), tbl[k].h, tbl[k].mi, tbl[k].s,
                    tbl[k].p, tbl[k].f);
         if (k < 18) check($sformatf("tbl%0d.sec_tick", k), int'(sec_tick), 0);
      end

      // Full rollovers
      do_reset();
      set_fields(11, 59, 59);
      check_time("set_1159am", 11, 59, 59, 0, 0);
      wait_tick("roll_am", 4);
      check_time("roll_am", 12, 0, 0, 1, 0);
      set_fields(11, 59, 59);
      check_time("set_1159pm", 11, 59, 59, 1, 0);
      wait_tick("roll_pm", 4);
      check_time("roll_pm", 12, 0, 0, 0, 0);
      set_fields(0, 59, 59);
      wait_tick("roll_12", 4);
      check_time("roll_12", 1, 0, 0, 0, 0);

      // Field wraps without carry, then resume timing
      do_reset();
      step(1'b1, 1'b0);
      step(1'b1, 1'b0);
      incs(59);
      check_time("mins59", 12, 59, 0, 0, 2);
      step(1'b0, 1'b1);
      check_time("mins_wrap", 12, 0, 0, 0, 2);
      step(1'b1, 1'b0);
      incs(59);
      check_time("secs59", 12, 0, 59, 0, 3);
      step(1'b0, 1'b1);
      check_time("secs_wrap", 12, 0, 0, 0, 3);
      step(1'b1, 1'b0);
      check_time("back_run", 12, 0, 0, 0, 0);
      wait_tick("resume", 4);
      check_time("resume", 12, 0, 1, 0, 0);

      // inc_btn ignored in RUN
      step(1'b0, 1'b1);
      check_time("run_inc", 12, 0, 1, 0, 0);

      // Reset while in SET_M after changing fields
      step(1'b1, 1'b0);
      step(1'b0, 1'b1);
      step(1'b1, 1'b0);
      step(1'b0, 1'b1);
      check_time("pre_rst", 1, 1, 1, 0, 2);
      do_reset();
      check_time("rst_setm", 12, 0, 0, 0, 0);
      check("rst_setm.sec_tick", int'(sec_tick), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
